// File: rtl/fp_flag_pipe_if.sv
// fp_flag_pipe_if: operand, handshake, flag and status signals of the FP flag pipeline
interface fp_flag_pipe_if #(parameter int EW = 8, parameter int MW = 23);
  logic          in_valid, in_ready, in_mode;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] ma, mb, mr;
  logic [EW+1:0] ep;
  logic [MW:0]   mx;
  logic          out_valid, out_ready;
  logic          res_nan, res_inf, res_zero, res_dn;
  logic          round, overflow, underflow, inexact;
  logic          div_by_zero, invalid;
  logic          status_clr;
  logic [4:0]    status;
  modport master (
    output in_valid, in_mode, ea, eb, ma, mb, ep, mr, mx, out_ready, status_clr,
    input  in_ready, out_valid, res_nan, res_inf, res_zero, res_dn, round, overflow,
           underflow, inexact, div_by_zero, invalid, status
  );
  modport slave (
    input  in_valid, in_mode, ea, eb, ma, mb, ep, mr, mx, out_ready, status_clr,
    output in_ready, out_valid, res_nan, res_inf, res_zero, res_dn, round, overflow,
           underflow, inexact, div_by_zero, invalid, status
  );
endinterface

// File: rtl/fp_flag_pipe.sv
// fp_flag_pipe: two-stage special-case, rounding and exception-flag pipeline with sticky status
module fp_flag_pipe #(parameter int EW = 8, parameter int MW = 23) (
  input logic clk,
  input logic rst,
  fp_flag_pipe_if.slave bus
);
  logic [3:0] a_cls, b_cls, s1_a, s1_b;
  logic       s1_valid, s1_mode, s1_dz, s1_rnd, s1_inx, s1_ovf, s1_unf;
  logic       s2_valid, s2_load, in_fire, out_fire;
  logic [9:0] f, s2_f;
  logic [4:0] status;
  logic       a_zero, a_dn, a_inf, a_nan, a_fin, b_zero, b_dn, b_inf, b_nan, b_fin;
  logic       nan, inf, zero, special;
  // class bits are {zero, denormal, inf, nan}
  function automatic logic [3:0] classify(input logic [EW-1:0] e, input logic [MW-1:0] m);
    return {~|e & ~|m, ~|e & |m, &e & ~|m, &e & |m};
  endfunction
  assign a_cls = classify(bus.ea, bus.ma);
  assign b_cls = classify(bus.eb, bus.mb);
  assign {a_zero, a_dn, a_inf, a_nan} = s1_a;
  assign {b_zero, b_dn, b_inf, b_nan} = s1_b;
  assign a_fin = ~(a_inf | a_nan);
  assign b_fin = ~(b_inf | b_nan);
  assign s2_load = ~s2_valid | bus.out_ready;
  assign bus.in_ready = ~s1_valid | s2_load;
  assign in_fire = bus.in_valid & bus.in_ready;
  assign out_fire = s2_valid & bus.out_ready;
  always_comb begin
    nan = s1_mode ? (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf))
                  : (a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero));
    inf = ~nan & (s1_mode ? ((a_inf & b_fin) | (b_zero & a_fin & ~a_zero)) : (a_inf | b_inf));
    zero = ~nan & (s1_mode ? ((a_zero & ~b_zero) | (b_inf & a_fin)) : (a_zero | b_zero));
    special = nan | inf | zero;
    f = {nan, inf, zero, (a_dn | b_dn) & ~special, s1_rnd & ~special, s1_ovf & ~special,
         s1_unf & ~special, s1_inx & ~special, s1_dz, nan & ~a_nan & ~b_nan};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_mode <= 1'b0;
      s1_dz <= 1'b0;
      s1_rnd <= 1'b0;
      s1_inx <= 1'b0;
      s1_ovf <= 1'b0;
      s1_unf <= 1'b0;
      s2_valid <= 1'b0;
      s2_f <= '0;
      status <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_a <= a_cls;
        s1_b <= b_cls;
        s1_mode <= bus.in_mode;
        s1_dz <= bus.in_mode & b_cls[3] & ~a_cls[3] & ~a_cls[1] & ~a_cls[0];
        s1_rnd <= bus.mx[MW] & (bus.mr[0] | |bus.mx[MW-1:0]);
        s1_inx <= |bus.mx;
        s1_ovf <= $signed(bus.ep) >= $signed({2'b00, {EW{1'b1}}});
        s1_unf <= bus.ep[EW+1] | ~|bus.ep;
      end
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load & s1_valid) s2_f <= f;
      status <= (bus.status_clr ? 5'b0 : status) |
                (out_fire ? {s2_f[0], s2_f[1], s2_f[4], s2_f[3], s2_f[2]} : 5'b0);
    end
  end
  assign bus.out_valid = s2_valid;
  assign bus.status = status;
  assign {bus.res_nan, bus.res_inf, bus.res_zero, bus.res_dn, bus.round, bus.overflow,
          bus.underflow, bus.inexact, bus.div_by_zero, bus.invalid} = s2_f;
endmodule

// File: doc/fp_flag_pipe.md
# fp_flag_pipe

Parametrised, pipelined special-case and exception-flag generator for the FP multiply/divide datapath. It classifies the two raw operands and resolves the special result (NaN/Inf/zero/denormal) for multiply or divide mode. It evaluates round-to-nearest-even, overflow and underflow from the datapath's intermediate exponent and mantissa. Results move through a 2-stage valid/ready pipeline, and IEEE-style exceptions accumulate into a sticky status register.

## Interface
- EW, 8, exponent field width (≥3)
- MW, 23, fraction field width (≥2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_mode  in  1  0 = multiply, 1 = divide
- ea, eb  in  EW  biased exponent fields of A, B
- ma, mb  in  MW  fraction fields of A, B
- ep  in  EW+2  intermediate result exponent, two's complement
- mr  in  MW  retained result fraction
- mx  in  MW+1  discarded bits; mx[MW] = guard, rest = sticky source
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- res_nan, res_inf, res_zero, res_dn  out  1 each  resolved special result / denormal-operand indication
- round, overflow, underflow, inexact  out  1 each  rounding/range flags
- div_by_zero, invalid  out  1 each  exception flags for this beat
- status_clr  in  1  clear sticky status
- status  out  5  sticky {invalid, div_by_zero, overflow, underflow, inexact}

## Operation
- Operand classes (X = A or B): ez = exponent all-zero, eh = exponent all-ones, fz = fraction zero. X_zero = ez&fz; X_dn = ez&~fz; X_inf = eh&fz; X_nan = eh&~fz; X_fin = ~eh.
- Multiply: nan = a_nan|b_nan|(a_zero&b_inf)|(a_inf&b_zero). inf = (a_inf|b_inf)&~nan. zero = (a_zero|b_zero)&~nan.
- Divide: nan = a_nan|b_nan|(a_zero&b_zero)|(a_inf&b_inf). inf = ((a_inf&b_fin)|(b_zero&a_fin&~a_zero))&~nan. zero = ((a_zero&~b_zero)|(b_inf&a_fin))&~nan.
- div_by_zero = in_mode & b_zero & a_fin & ~a_zero.
- invalid = res_nan & ~a_nan & ~b_nan. Operand NaNs propagate quietly.
- special = res_nan|res_inf|res_zero. res_dn = (a_dn|b_dn) & ~special.
- round = mx[MW] & (mr[0] | |mx[MW-1:0]) & ~special.
- inexact = |mx & ~special.
- overflow = (ep signed ≥ 2^EW−1) & ~special. underflow = (ep signed ≤ 0) & ~special.
- Priority among results: nan > inf > zero. At most one of the three is set.
- Status update on each output handshake (out_valid&out_ready): status ← (status_clr ? 0 : status) | {invalid, div_by_zero, overflow, underflow, inexact}.
- Without a handshake: status ← status_clr ? 0 : status.
- A clear and an event in the same cycle leave only that event's bits set.

## Timing
- Stage 1 registers the operand classes, mode, div-by-zero precursor, round, inexact and range bits. Stage 2 registers the resolved outputs.
- Latency is exactly 2 cycles from the input handshake to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Stage k loads when it is empty or its contents advance this cycle.
- in_ready = ~s1_valid | ~s2_valid | out_ready.
- The stall is elastic: with out_ready low, 2 beats are held. No beat is lost, duplicated or reordered.
- Outputs are stable while out_valid & ~out_ready.
- Inputs are sampled only on in_valid & in_ready.
- Reset (any time, including mid-stall): both valids = 0 and all flag outputs = 0; status = 0. in_ready = 1 from the first cycle after release.
- Buffered beats are discarded on reset.

## Test plan
- Mul 0×Inf (EW=8, MW=23): ea=0, ma=0, eb=0xFF, mb=0, one beat -> 2 cycles later out_valid=1, res_nan=1, invalid=1, other flags 0; status=5'b10000 after handshake.
- Div 1.0/0: in_mode=1, ea=0x7F, ma=0, eb=0, mb=0 -> res_inf=1, div_by_zero=1, invalid=0.
- Div 0/0 -> res_nan=1, invalid=1, div_by_zero=0.
- RNE on normal operands with ep=0x07F:
  - mx=0x800000, mr=0x000000 -> round=0, inexact=1.
  - mx=0x800000, mr=0x000001 -> round=1.
  - mx=0x800001, mr=0x000000 -> round=1.
  - mx=0 -> round=0, inexact=0.
- Range checks on normal operands:
  - ep=0x0FE -> no range flags.
  - ep=0x0FF -> overflow=1.
  - ep=0x000 -> underflow=1.
  - ep=0x3FF (−1) -> underflow=1.
  - Same range-triggering ep with A = Inf -> overflow=0, underflow=0.
- Backpressure: hold out_ready=0 and drive 4 back-to-back beats.
  - in_ready drops after 2 are accepted.
  - With out_ready=1 the beats emerge in order with correct flags, 1/cycle.
- Status clear: assert status_clr in the same cycle as an overflow handshake -> status=5'b00100.
- Reset mid-stall: assert rst low during the stall -> out_valid=0 and status=0 immediately, with no stale beat after release.
